// File: rtl/force_integrator.sv
// force_integrator: semi-implicit Euler integrator for a soft-body model.
// Each frame streams one force beat per node (in node order) followed by an
// axle force. Each beat updates velocity first and then position with the new
// velocity. Both results saturate to their signed range.
module force_integrator #(
  parameter int NUM_NODES     = 10,
  parameter int POSITION_SIZE = 8,
  parameter int VELOCITY_SIZE = 8,
  parameter int FORCE_SIZE    = 8,
  parameter int DT_SHIFT      = 2
) (
  input  logic                            clk_in,
  input  logic                            rst_in,
  input  logic                            init_valid,
  input  logic signed [POSITION_SIZE-1:0] init_nodes         [1:0][NUM_NODES],
  input  logic signed [VELOCITY_SIZE-1:0] init_velocities    [1:0][NUM_NODES],
  input  logic signed [POSITION_SIZE-1:0] init_axle          [1:0],
  input  logic signed [VELOCITY_SIZE-1:0] init_axle_velocity [1:0],
  input  logic                            start,
  input  logic signed [FORCE_SIZE-1:0]    force_x_in,
  input  logic signed [FORCE_SIZE-1:0]    force_y_in,
  input  logic                            force_in_valid,
  input  logic signed [FORCE_SIZE-1:0]    axle_force_x,
  input  logic signed [FORCE_SIZE-1:0]    axle_force_y,
  input  logic                            axle_force_valid,
  output logic signed [POSITION_SIZE-1:0] nodes              [1:0][NUM_NODES],
  output logic signed [VELOCITY_SIZE-1:0] velocities         [1:0][NUM_NODES],
  output logic signed [POSITION_SIZE-1:0] axle               [1:0],
  output logic signed [VELOCITY_SIZE-1:0] axle_velocity      [1:0],
  output logic                            busy,
  output logic                            update_done,
  output logic                            frame_err
);

  // Intermediate width: widest operand plus two guard bits, so a sum of two
  // sign-extended operands can never wrap before saturation.
  localparam int MAX_PV = (POSITION_SIZE > VELOCITY_SIZE) ? POSITION_SIZE : VELOCITY_SIZE;
  localparam int MAX_W  = (MAX_PV > FORCE_SIZE) ? MAX_PV : FORCE_SIZE;
  localparam int W      = MAX_W + 2;

  // Index counts 0..NUM_NODES; NUM_NODES itself means "all nodes received".
  localparam int                IDXW     = $clog2(NUM_NODES + 1);
  localparam logic [IDXW-1:0]   IDX_FULL = IDXW'(NUM_NODES);

  typedef enum logic [0:0] {
    S_IDLE    = 1'b0,
    S_COLLECT = 1'b1
  } state_t;

  state_t          state_q;
  logic [IDXW-1:0] idx_q;
  logic [IDXW-1:0] idx_d;
  logic            busy_q;
  logic            done_q;
  logic            err_q;

  logic                 load_init;
  logic                 beat_ok;
  logic                 beat_over;
  logic                 axle_we;
  logic [NUM_NODES-1:0] node_we;

  // Per-axis views of the incoming forces (axis 0 = x, axis 1 = y).
  logic signed [FORCE_SIZE-1:0] node_force [2];
  logic signed [FORCE_SIZE-1:0] axle_force [2];

  assign node_force[0] = force_x_in;
  assign node_force[1] = force_y_in;
  assign axle_force[0] = axle_force_x;
  assign axle_force[1] = axle_force_y;

  // ---------------------------------------------------------------------------
  // Saturating arithmetic helpers
  // ---------------------------------------------------------------------------

  // Clamp a wide intermediate to the signed velocity range.
  function automatic logic signed [VELOCITY_SIZE-1:0] sat_vel(input logic signed [W-1:0] s);
    logic signed [W-1:0] hi;
    logic signed [W-1:0] lo;
    hi = $signed({{(W-VELOCITY_SIZE+1){1'b0}}, {(VELOCITY_SIZE-1){1'b1}}});
    lo = $signed({{(W-VELOCITY_SIZE+1){1'b1}}, {(VELOCITY_SIZE-1){1'b0}}});
    if (s > hi) begin
      return hi[VELOCITY_SIZE-1:0];
    end else if (s < lo) begin
      return lo[VELOCITY_SIZE-1:0];
    end
    return s[VELOCITY_SIZE-1:0];
  endfunction

  // Clamp a wide intermediate to the signed position range.
  function automatic logic signed [POSITION_SIZE-1:0] sat_pos(input logic signed [W-1:0] s);
    logic signed [W-1:0] hi;
    logic signed [W-1:0] lo;
    hi = $signed({{(W-POSITION_SIZE+1){1'b0}}, {(POSITION_SIZE-1){1'b1}}});
    lo = $signed({{(W-POSITION_SIZE+1){1'b1}}, {(POSITION_SIZE-1){1'b0}}});
    if (s > hi) begin
      return hi[POSITION_SIZE-1:0];
    end else if (s < lo) begin
      return lo[POSITION_SIZE-1:0];
    end
    return s[POSITION_SIZE-1:0];
  endfunction

  // v' = sat(v + f*dt); unit mass, so acceleration equals force.
  function automatic logic signed [VELOCITY_SIZE-1:0] vel_step(
    input logic signed [VELOCITY_SIZE-1:0] v,
    input logic signed [FORCE_SIZE-1:0]    f
  );
    logic signed [W-1:0] v_w;
    logic signed [W-1:0] f_w;
    v_w = {{(W-VELOCITY_SIZE){v[VELOCITY_SIZE-1]}}, v};
    f_w = {{(W-FORCE_SIZE){f[FORCE_SIZE-1]}}, f};
    return sat_vel(v_w + (f_w >>> DT_SHIFT));
  endfunction

  // p' = sat(p + v'*dt), using the already-updated velocity.
  function automatic logic signed [POSITION_SIZE-1:0] pos_step(
    input logic signed [POSITION_SIZE-1:0] p,
    input logic signed [VELOCITY_SIZE-1:0] v_new
  );
    logic signed [W-1:0] p_w;
    logic signed [W-1:0] v_w;
    p_w = {{(W-POSITION_SIZE){p[POSITION_SIZE-1]}}, p};
    v_w = {{(W-VELOCITY_SIZE){v_new[VELOCITY_SIZE-1]}}, v_new};
    return sat_pos(p_w + (v_w >>> DT_SHIFT));
  endfunction

  // ---------------------------------------------------------------------------
  // Frame control decode
  // ---------------------------------------------------------------------------

  assign load_init = (state_q == S_IDLE) && init_valid;
  assign beat_ok   = (state_q == S_COLLECT) && force_in_valid && (idx_q < IDX_FULL);
  assign beat_over = (state_q == S_COLLECT) && force_in_valid && (idx_q >= IDX_FULL);
  assign axle_we   = (state_q == S_COLLECT) && axle_force_valid;

  // Post-increment index: a beat coinciding with the axle force counts
  // toward completeness of the frame.
  assign idx_d = beat_ok ? (idx_q + IDXW'(1)) : idx_q;

  // Frame FSM: sequences IDLE/COLLECT, tracks node index and status flags.
  always_ff @(posedge clk_in) begin
    if (!rst_in) begin
      state_q <= S_IDLE;
      idx_q   <= '0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        S_IDLE: begin
          if (start) begin
            state_q <= S_COLLECT;
            idx_q   <= '0;
            err_q   <= 1'b0;
            busy_q  <= 1'b1;
          end
        end
        S_COLLECT: begin
          idx_q <= idx_d;
          if (beat_over) begin
            err_q <= 1'b1;
          end
          if (axle_force_valid) begin
            if (idx_d != IDX_FULL) begin
              err_q <= 1'b1;
            end
            state_q <= S_IDLE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
          end
        end
        default: begin
          state_q <= S_IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign busy        = busy_q;
  assign update_done = done_q;
  assign frame_err   = err_q;

  // ---------------------------------------------------------------------------
  // Node state: one position/velocity register pair per node per axis
  // ---------------------------------------------------------------------------

  for (genvar gi = 0; gi < NUM_NODES; gi++) begin : g_node
    assign node_we[gi] = beat_ok && (idx_q == IDXW'(gi));

    for (genvar gj = 0; gj < 2; gj++) begin : g_axis
      logic signed [POSITION_SIZE-1:0] pos_q;
      logic signed [POSITION_SIZE-1:0] pos_d;
      logic signed [VELOCITY_SIZE-1:0] vel_q;
      logic signed [VELOCITY_SIZE-1:0] vel_d;

      assign vel_d = vel_step(vel_q, node_force[gj]);
      assign pos_d = pos_step(pos_q, vel_d);

      // Node register: reset, initial load in IDLE, or integrate on its beat.
      always_ff @(posedge clk_in) begin
        if (!rst_in) begin
          pos_q <= '0;
          vel_q <= '0;
        end else if (load_init) begin
          pos_q <= init_nodes[gj][gi];
          vel_q <= init_velocities[gj][gi];
        end else if (node_we[gi]) begin
          pos_q <= pos_d;
          vel_q <= vel_d;
        end
      end

      assign nodes[gj][gi]      = pos_q;
      assign velocities[gj][gi] = vel_q;
    end
  end

  // ---------------------------------------------------------------------------
  // Axle state
  // ---------------------------------------------------------------------------

  for (genvar gj = 0; gj < 2; gj++) begin : g_axle
    logic signed [POSITION_SIZE-1:0] pos_q;
    logic signed [POSITION_SIZE-1:0] pos_d;
    logic signed [VELOCITY_SIZE-1:0] vel_q;
    logic signed [VELOCITY_SIZE-1:0] vel_d;

    assign vel_d = vel_step(vel_q, axle_force[gj]);
    assign pos_d = pos_step(pos_q, vel_d);

    // Axle register: reset, initial load in IDLE, or integrate at frame end.
    always_ff @(posedge clk_in) begin
      if (!rst_in) begin
        pos_q <= '0;
        vel_q <= '0;
      end else if (load_init) begin
        pos_q <= init_axle[gj];
        vel_q <= init_axle_velocity[gj];
      end else if (axle_we) begin
        pos_q <= pos_d;
        vel_q <= vel_d;
      end
    end

    assign axle[gj]          = pos_q;
    assign axle_velocity[gj] = vel_q;
  end

endmodule
